// File: rtl/btn_accumulator.sv
// -----------------------------------------------------------------------------
// btn_accumulator
//
// Purpose:
//   Debounces three raw push buttons (load, add, clr) and uses the resulting
//   one-cycle press pulses to drive an 8-bit accumulator. The accumulator is
//   cleared, loaded from the switches, or has the switches added to it. A
//   sticky carry flag records any add overflow. The outputs feed the two-digit
//   seven-segment display path and a carry LED.
//
// Parameters:
//   WIDTH            accumulator / switch width in bits
//   DEBOUNCE_CYCLES  clocks a raw level must stay stable before it is accepted
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   CLK       in   1      system clock, rising edge
//   RST_N     in   1      asynchronous active-low reset
//   btn_load  in   1      raw load button, active-high, asynchronous
//   btn_add   in   1      raw add button, active-high, asynchronous
//   btn_clr   in   1      raw clear button, active-high, asynchronous
//   sw        in   WIDTH  switch operand, sampled on the execute cycle
//   value     out  WIDTH  accumulator contents (registered)
//   carry     out  1      sticky add-overflow flag (registered)
//   press     out  3      debounced press pulses {clr, add, load} (registered)
// -----------------------------------------------------------------------------
module btn_accumulator #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             btn_load,
  input  logic             btn_add,
  input  logic             btn_clr,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic [2:0]       press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order matches the press output: {clr, add, load}.
  logic [2:0] btn_raw;
  logic [2:0] press_q;

  assign btn_raw = {btn_clr, btn_add, btn_load};

  // ---------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and rising-edge detector
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             stable_q;
      logic             stable_d;
      logic             stable_dly_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // The counter only runs while the synchronised level disagrees with the
      // accepted level; any return to the accepted level restarts it.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
          if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          stable_q     <= 1'b0;
          stable_dly_q <= 1'b0;
          cnt_q        <= '0;
          press_q[gi]  <= 1'b0;
        end else begin
          sync1_q      <= btn_raw[gi];
          sync2_q      <= sync1_q;
          stable_q     <= stable_d;
          stable_dly_q <= stable_q;
          cnt_q        <= cnt_d;
          // Pulse on the cycle after the accepted level rises; releases are
          // debounced identically but never produce a pulse.
          press_q[gi]  <= stable_q & ~stable_dly_q;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Accumulator: executes the cycle after a press pulse, clr > load > add
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             carry_q;
  logic             carry_d;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, value_q} + {1'b0, sw};

  always_comb begin
    value_d = value_q;
    carry_d = carry_q;
    if (press_q[2]) begin
      value_d = '0;
      carry_d = 1'b0;
    end else if (press_q[0]) begin
      value_d = sw;
      carry_d = 1'b0;
    end else if (press_q[1]) begin
      value_d = sum[WIDTH-1:0];
      carry_d = carry_q | sum[WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      value_q <= '0;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

  assign value = value_q;
  assign carry = carry_q;
  assign press = press_q;

endmodule

// File: tb/tb_btn_accumulator.sv
// -----------------------------------------------------------------------------
// tb_btn_accumulator
//
// Purpose:
//   Self-checking bench for btn_accumulator with a short debounce window
//   (DEBOUNCE_CYCLES=4, CNT_W=3). Each button operation pushes its expected
//   press bits, press cycle and resulting value/carry onto a scoreboard queue;
//   a monitor pops an entry whenever a press pulse appears and checks the
//   accumulator on the following cycle. Presses with no pending entry are
//   reported as unexpected.
// -----------------------------------------------------------------------------
module tb_btn_accumulator;

  localparam int WIDTH   = 8;
  localparam int DEB     = 4;
  localparam int LATENCY = 2 + DEB + 1;

  logic             CLK;
  logic             RST_N;
  logic [2:0]       btn_tb;   // {clr, add, load}
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] value;
  logic             carry;
  logic [2:0]       press;

  btn_accumulator #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .btn_load(btn_tb[0]),
    .btn_add (btn_tb[1]),
    .btn_clr (btn_tb[2]),
    .sw      (sw),
    .value   (value),
    .carry   (carry),
    .press   (press)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]       press;
    logic [WIDTH-1:0] value;
    logic             carry;
    int               cyc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] model_value = '0;
  logic             model_carry = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard on every press pulse, checks value/carry the
  // cycle after.
  // ---------------------------------------------------------------------------
  logic             vc_pending = 1'b0;
  logic [WIDTH-1:0] vc_value;
  logic             vc_carry;

  always @(negedge CLK) begin
    exp_t e;
    if (vc_pending) begin
      chk("acc_value", value, vc_value);
      chk("acc_carry", carry, vc_carry);
      $display("txn done: value=%02h carry=%0d (cycle %0d)", value, carry, cyc);
      vc_pending = 1'b0;
    end
    if (press !== 3'b000) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_press", press, 3'b000);
      end else begin
        e = sb_q.pop_front();
        chk("press_bits", press, e.press);
        chk("press_cycle", cyc, e.cyc);
        vc_value   = e.value;
        vc_carry   = e.carry;
        vc_pending = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_drain(input int max_cycles);
    bit drained = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge CLK);
      #1;
      if (sb_q.size() == 0 && !vc_pending) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) chk("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Applies the reference model for one operation and queues the expectation.
  task automatic push_op(input logic [2:0] bits, input logic [WIDTH-1:0] swv, input int at_cyc);
    logic [WIDTH:0] s;
    exp_t e;
    if (bits[2]) begin
      model_value = '0;
      model_carry = 1'b0;
    end else if (bits[0]) begin
      model_value = swv;
      model_carry = 1'b0;
    end else if (bits[1]) begin
      s           = {1'b0, model_value} + {1'b0, swv};
      model_value = s[WIDTH-1:0];
      model_carry = model_carry | s[WIDTH];
    end
    e.press = bits;
    e.value = model_value;
    e.carry = model_carry;
    e.cyc   = at_cyc;
    sb_q.push_back(e);
  endtask

  // Raise the given buttons together, hold, release and let release settle.
  task automatic press_op(input logic [2:0] bits, input logic [WIDTH-1:0] swv, input int hold);
    @(negedge CLK);
    sw = swv;
    push_op(bits, swv, cyc + LATENCY);
    btn_tb = bits;
    idle(hold);
    btn_tb = 3'b000;
    wait_drain(40);
    idle(10);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    RST_N  = 1'b0;
    btn_tb = 3'b000;
    sw     = '0;

    // Reset state
    idle(3);
    chk("rst_value", value, 0);
    chk("rst_carry", carry, 0);
    chk("rst_press", press, 0);
    RST_N = 1'b1;

    // 1. Idle
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("idle_value", value, 0);
      chk("idle_carry", carry, 0);
      chk("idle_press", press, 0);
    end

    // 2. Long hold on load yields exactly one press
    press_op(3'b001, 8'h3C, 40);

    // 3. Add with overflow, sticky carry, then clear
    press_op(3'b001, 8'hF0, 10);
    press_op(3'b010, 8'h20, 10);
    press_op(3'b010, 8'h01, 10);
    press_op(3'b100, 8'h00, 10);

    // Non-zero value before the glitch and coincidence tests
    press_op(3'b001, 8'h99, 10);

    // 4. Short add pulses are rejected
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      btn_tb[1] = 1'b1;
      idle(1);
      @(negedge CLK);
      btn_tb[1] = 1'b0;
      idle(1);
    end
    idle(15);
    chk("glitch_value", value, model_value);
    chk("glitch_carry", carry, model_carry);

    // 5. clr and load together: both pulse, clr wins
    press_op(3'b101, 8'h77, 10);

    // 6. Reset in the middle of a debounce count
    @(negedge CLK);
    sw        = 8'h5A;
    btn_tb[1] = 1'b1;
    idle(4);                 // debounce count has reached 2
    RST_N       = 1'b0;
    model_value = '0;
    model_carry = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rstmid_press", press, 0);
      chk("rstmid_value", value, 0);
    end
    RST_N = 1'b1;
    push_op(3'b010, 8'h5A, cyc + LATENCY);
    idle(20);
    btn_tb[1] = 1'b0;
    wait_drain(40);
    idle(10);

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
